// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed big-endian data memory for the MEM stage.
// Handles byte/half/word loads and stores behind a req/done handshake with
// programmable wait states. Also flags alignment, range and size errors, and
// provides a combinational debug word-read port.
module data_memory_ctrl #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned MEM_CELL_SIZE = 8,
  parameter int unsigned DATA_MEM_SIZE = 64,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_step,
  input  logic                i_req,
  input  logic                i_write_en,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [WORD_LEN-1:0] i_addr,
  input  logic [WORD_LEN-1:0] i_data,
  input  logic [WORD_LEN-1:0] i_dbg_addr,
  output logic                o_ready,
  output logic                o_done,
  output logic                o_err,
  output logic [WORD_LEN-1:0] o_data,
  output logic [WORD_LEN-1:0] o_dbg_data
);

  localparam int unsigned AW    = $clog2(DATA_MEM_SIZE);
  localparam int unsigned CW    = 4;
  localparam int unsigned M     = MEM_CELL_SIZE;
  localparam int unsigned EXT_B = WORD_LEN - M;
  localparam int unsigned EXT_H = WORD_LEN - 2 * M;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  lat_we;
  logic [1:0]            lat_size;
  logic                  lat_uns;
  logic [WORD_LEN-1:0]   lat_addr;
  logic [WORD_LEN-1:0]   lat_data;
  logic [M-1:0]          mem [DATA_MEM_SIZE];

  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_uns;
  logic [WORD_LEN-1:0]   op_addr;
  logic [WORD_LEN-1:0]   op_data;
  logic [WORD_LEN:0]     op_nbytes;
  logic [WORD_LEN:0]     op_end;
  logic                  op_err;
  logic [AW-1:0]         ia;
  logic [M-1:0]          b0, b1, b2, b3;
  logic                  ext;
  logic [WORD_LEN-1:0]   load_val;
  logic                  enter_done_c;
  logic [M-1:0]          dbg_b [4];
  logic [WORD_LEN:0]     didx;

  // Operand select: in IDLE the live inputs (zero-wait accept), else the latched request
  always_comb begin
    op_we   = lat_we;
    op_size = lat_size;
    op_uns  = lat_uns;
    op_addr = lat_addr;
    op_data = lat_data;
    if (state == S_IDLE) begin
      op_we   = i_write_en;
      op_size = i_size;
      op_uns  = i_unsigned;
      op_addr = i_addr;
      op_data = i_data;
    end
  end

  // Error detection and big-endian load assembly for the selected operand
  always_comb begin
    case (op_size)
      SZ_BYTE: op_nbytes = (WORD_LEN+1)'(1);
      SZ_HALF: op_nbytes = (WORD_LEN+1)'(2);
      SZ_WORD: op_nbytes = (WORD_LEN+1)'(4);
      default: op_nbytes = '0;
    endcase
    op_end = {1'b0, op_addr} + op_nbytes;
    op_err = (op_size == 2'b10)
           | ((op_size == SZ_HALF) & op_addr[0])
           | ((op_size == SZ_WORD) & (op_addr[1:0] != 2'b00))
           | (op_end > (WORD_LEN+1)'(DATA_MEM_SIZE));
    ia  = AW'(op_addr);
    b0  = mem[ia];
    b1  = mem[AW'(ia + AW'(1))];
    b2  = mem[AW'(ia + AW'(2))];
    b3  = mem[AW'(ia + AW'(3))];
    ext = b0[M-1] & ~op_uns;
    case (op_size)
      SZ_BYTE: load_val = {{EXT_B{ext}}, b0};
      SZ_HALF: load_val = {{EXT_H{ext}}, b0, b1};
      SZ_WORD: load_val = {b0, b1, b2, b3};
      default: load_val = '0;
    endcase
  end

  // Marks the step edge on which the access completes (commit / sample point)
  always_comb begin
    enter_done_c = 1'b0;
    case (state)
      S_IDLE:  enter_done_c = i_step & i_req & (WAIT_STATES == 0);
      S_WAIT:  enter_done_c = i_step & (cnt == CNT_LAST);
      default: enter_done_c = 1'b0;
    endcase
  end

  // Control FSM, wait counter, registered outputs and memory array
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_we   <= 1'b0;
      lat_size <= '0;
      lat_uns  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      o_ready  <= 1'b1;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      for (int unsigned i = 0; i < DATA_MEM_SIZE; i++) mem[i] <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_step && i_req) begin
            lat_we   <= i_write_en;
            lat_size <= i_size;
            lat_uns  <= i_unsigned;
            lat_addr <= i_addr;
            lat_data <= i_data;
            cnt      <= '0;
            o_ready  <= 1'b0;
            state    <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_step) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
      if (enter_done_c) begin
        o_done <= 1'b1;
        o_err  <= op_err;
        if (op_err) begin
          o_data <= '0;
        end else if (!op_we) begin
          o_data <= load_val;
        end else begin
          case (op_size)
            SZ_BYTE: mem[ia] <= op_data[M-1:0];
            SZ_HALF: begin
              mem[ia]              <= op_data[2*M-1 -: M];
              mem[AW'(ia + AW'(1))] <= op_data[M-1:0];
            end
            SZ_WORD: begin
              mem[ia]              <= op_data[4*M-1 -: M];
              mem[AW'(ia + AW'(1))] <= op_data[3*M-1 -: M];
              mem[AW'(ia + AW'(2))] <= op_data[2*M-1 -: M];
              mem[AW'(ia + AW'(3))] <= op_data[M-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Debug word read; bytes past the end of memory read as zero
  always_comb begin
    didx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      dbg_b[k] = '0;
      didx = {1'b0, i_dbg_addr} + (WORD_LEN+1)'(k);
      if (didx < (WORD_LEN+1)'(DATA_MEM_SIZE)) dbg_b[k] = mem[AW'(didx)];
    end
    o_dbg_data = {dbg_b[0], dbg_b[1], dbg_b[2], dbg_b[3]};
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: randomized and directed checks of data_memory_ctrl
// against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

  localparam int unsigned WS   = 1;
  localparam int unsigned MSZ  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dbg_addr;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] dbg_data;

  int tests = 0;
  int fails = 0;

  byte unsigned mem_m [MSZ];
  logic [31:0]  exp_data;

  data_memory_ctrl #(
    .WORD_LEN(32), .MEM_CELL_SIZE(8), .DATA_MEM_SIZE(MSZ), .WAIT_STATES(WS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_req(req),
    .i_write_en(we), .i_size(size), .i_unsigned(uns), .i_addr(addr),
    .i_data(wdata), .i_dbg_addr(dbg_addr), .o_ready(ready), .o_done(done),
    .o_err(err), .o_data(rdata), .o_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference: debug word view of the model memory
  function automatic logic [31:0] m_dbg(input logic [31:0] a);
    logic [31:0] r = 0;
    for (int k = 0; k < 4; k++) begin
      longint idx = longint'(a) + k;
      r = r << 8;
      if (idx < MSZ) r = r | 32'(mem_m[idx]);
    end
    return r;
  endfunction

  // Reference: performs one access on the model, returns expected err and o_data
  function automatic void m_access(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] d,
                                   output logic e, output logic [31:0] r);
    int nb;
    longint v;
    case (sz)
      2'b00: nb = 1;
      2'b01: nb = 2;
      2'b11: nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0) e = 1'b1;
    else e = ((a % nb) != 0) || (longint'(a) + nb > MSZ);
    if (e) begin
      exp_data = 0;
    end else if (w) begin
      for (int k = 0; k < nb; k++) mem_m[a + k] = 8'(d >> (8 * (nb - 1 - k)));
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v * 256 + mem_m[a + k];
      if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      exp_data = 32'(v);
    end
    r = exp_data;
  endfunction

  // Issues one access; optionally gates i_step randomly and toggles req/operands while busy
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input bit noisy,
                        output int steps, output logic [31:0] got_d, output logic got_e,
                        output bit timeout);
    @(negedge clk);
    step = 1'b1; req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    steps = 1;
    timeout = 1'b1;
    got_d = 'x; got_e = 'x;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        got_d = rdata; got_e = err; timeout = 1'b0;
        req = 1'b0;
        break;
      end
      if (noisy) begin
        step = ($urandom_range(0, 3) != 0);
        req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wdata = $urandom; uns = 1'($urandom);
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
      if (step) steps++;
    end
    step = 1'b1;
    req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; step = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 0;
    exp_data = 0;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (err !== 1'b0)   begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", rdata); end
    for (int a = 0; a <= 60; a += 4) begin
      dbg_addr = 32'(a); #1;
      tests++;
      if (dbg_data !== 32'h0) begin fails++; $display("FAIL reset_dbg@%0d got=%h exp=0", a, dbg_data); end
    end
  endtask

  // One access with full checking against the model
  task automatic check_op(input string nm, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input bit noisy);
    int steps; logic [31:0] gd; logic ge; bit to; logic ee; logic [31:0] ed;
    access(w, sz, u, a, d, noisy, steps, gd, ge, to);
    m_access(w, sz, u, a, d, ee, ed);
    tests++;
    if (to) begin
      fails++; $display("FAIL %s_timeout no o_done seen", nm);
    end else begin
      if (steps != WS + 1 || ge !== ee || gd !== ed) begin
        fails++;
        $display("FAIL %s a=%h sz=%b w=%b got steps=%0d err=%b data=%h exp steps=%0d err=%b data=%h",
                 nm, a, sz, w, steps, ge, gd, WS + 1, ee, ed);
      end
    end
  endtask

  task automatic check_dbg(input string nm, input logic [31:0] a);
    @(negedge clk);
    dbg_addr = a; #1;
    tests++;
    if (dbg_data !== m_dbg(a)) begin
      fails++; $display("FAIL %s dbg@%h got=%h exp=%h", nm, a, dbg_data, m_dbg(a));
    end
  endtask

  task automatic test_basic;
    check_op("st_word8", 1, 2'b11, 0, 32'd8, 32'hDEADBEEF, 0);
    check_op("ld_word8", 0, 2'b11, 0, 32'd8, 32'h0, 0);
    tests++; if (exp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_word8_model got=%h exp=deadbeef", exp_data); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL done_pulse done=%b ready=%b exp 0/1", done, ready); end
    check_dbg("dbg8", 32'd8);
    check_op("ld_byte_s", 0, 2'b00, 0, 32'd8, 0, 0);
    tests++; if (rdata !== 32'hFFFFFFDE) begin fails++; $display("FAIL ld_byte_s got=%h exp=ffffffde", rdata); end
    check_op("ld_byte_u", 0, 2'b00, 1, 32'd8, 0, 0);
    tests++; if (rdata !== 32'h000000DE) begin fails++; $display("FAIL ld_byte_u got=%h exp=000000de", rdata); end
    check_op("ld_half_s", 0, 2'b01, 0, 32'd10, 0, 0);
    tests++; if (rdata !== 32'hFFFFBEEF) begin fails++; $display("FAIL ld_half_s got=%h exp=ffffbeef", rdata); end
    check_op("st_byte63", 1, 2'b00, 0, 32'd63, 32'h0000_00A5, 0);
    check_op("st_half62", 1, 2'b01, 0, 32'd62, 32'h0000_7F81, 0);
    check_dbg("dbg61", 32'd61);
    check_dbg("dbg62", 32'd62);
  endtask

  task automatic test_errors;
    check_op("err_w6",   0, 2'b11, 0, 32'd6,  0, 0);
    check_op("err_h9",   0, 2'b01, 0, 32'd9,  0, 0);
    check_op("err_w62",  0, 2'b11, 0, 32'd62, 0, 0);
    check_op("err_sz10", 0, 2'b10, 0, 32'd0,  0, 0);
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL err_data got=%h exp=0", rdata); end
    check_op("err_st60", 1, 2'b11, 0, 32'd62, 32'h11223344, 0);
    check_op("err_stfar", 1, 2'b00, 0, 32'h8000_0000, 32'h55, 0);
    check_dbg("err_dbg60", 32'd60);
    check_dbg("err_dbg8", 32'd8);
  endtask

  task automatic test_step_hold;
    logic ee; logic [31:0] ed;
    @(negedge clk);
    step = 1'b1; req = 1'b1; we = 1'b0; size = 2'b11; uns = 1'b0; addr = 32'd8;
    @(negedge clk);
    step = 1'b0; req = 1'b1; addr = 32'd60; we = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || ready !== 1'b0) begin
        fails++; $display("FAIL hold_cycle%0d done=%b ready=%b exp 0/0", c, done, ready);
      end
    end
    step = 1'b1; req = 1'b0;
    @(negedge clk);
    m_access(0, 2'b11, 0, 32'd8, 0, ee, ed);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || rdata !== ed) begin
      fails++; $display("FAIL hold_resume done=%b err=%b data=%h exp 1/0/%h", done, err, rdata, ed);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL hold_ignored_req done=%b ready=%b exp 0/1", done, ready);
    end
    check_dbg("hold_dbg60", 32'd60);
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 68));
      check_op("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1);
      if (n % 4 == 0) check_dbg("rand_dbg", 32'($urandom_range(0, 66)));
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    step = 1'b1; req = 1'b1; we = 1'b1; size = 2'b11; uns = 1'b0; addr = 32'd12; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 0;
    exp_data = 0;
    tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid done=%b ready=%b exp 0/1", done, ready);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_late done=%b exp=0", done); end
    check_dbg("rst_mid_dbg12", 32'd12);
    check_op("post_rst_ld", 0, 2'b11, 0, 32'd12, 0, 0);
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; dbg_addr = '0;
    test_reset;
    test_basic;
    test_errors;
    test_step_hold;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
